// File: rtl/fifo_wr_arbiter_if.sv
// Bus interface for fifo_wr_arbiter: the two producer write ports, the consumer
// pop request, and the memory-side write strobe, data, addresses and status.
// The optional sticky error flags exist only when FIFO_WR_ARB_ERR_EN is defined.
interface fifo_wr_arbiter_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 3
);
    logic                  req0;
    logic [DATA_WIDTH-1:0] data0;
    logic                  grant0;
    logic                  req1;
    logic [DATA_WIDTH-1:0] data1;
    logic                  grant1;
    logic                  pop;
    logic                  mem_inc;
    logic [DATA_WIDTH-1:0] mem_data;
    logic [ADDR_WIDTH-1:0] w_addr;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic                  full;
    logic                  empty;
    logic [ADDR_WIDTH:0]   count;
`ifdef FIFO_WR_ARB_ERR_EN
    logic                  ovf_err;
    logic                  unf_err;

    // The producer/consumer side drives requests and reads grants and status.
    modport master (
        output req0, data0, req1, data1, pop,
        input  grant0, grant1, mem_inc, mem_data, w_addr, r_addr,
        input  full, empty, count, ovf_err, unf_err
    );

    // The arbiter side answers requests and drives the memory and status.
    modport slave (
        input  req0, data0, req1, data1, pop,
        output grant0, grant1, mem_inc, mem_data, w_addr, r_addr,
        output full, empty, count, ovf_err, unf_err
    );
`else
    // The producer/consumer side drives requests and reads grants and status.
    modport master (
        output req0, data0, req1, data1, pop,
        input  grant0, grant1, mem_inc, mem_data, w_addr, r_addr,
        input  full, empty, count
    );

    // The arbiter side answers requests and drives the memory and status.
    modport slave (
        input  req0, data0, req1, data1, pop,
        output grant0, grant1, mem_inc, mem_data, w_addr, r_addr,
        output full, empty, count
    );
`endif
endinterface

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: pointer controller and round-robin two-producer write arbiter
// for an 8-entry FIFO memory. Owns write/read pointers, occupancy and the memory
// write port. Optional sticky overflow/underflow flags are built in when the
// macro FIFO_WR_ARB_ERR_EN is defined.
module fifo_wr_arbiter #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 3
) (
    input logic             clk,
    input logic             rst,
    fifo_wr_arbiter_if.slave bus
);
    localparam int PW = ADDR_WIDTH + 1;

    logic [PW-1:0]         w_ptr;
    logic [PW-1:0]         r_ptr;
    logic [PW-1:0]         count_q;
    logic                  last;
    logic                  full_c;
    logic                  empty_c;
    logic                  grant0_c;
    logic                  grant1_c;
    logic                  push;
    logic                  pop_ok;
    logic [DATA_WIDTH-1:0] mem_data_c;

    // Status decode from the registered pointers: same low bits with differing
    // wrap bits means full, identical pointers mean empty.
    always_comb begin
        full_c  = (w_ptr[PW-1] != r_ptr[PW-1]) &&
                  (w_ptr[ADDR_WIDTH-1:0] == r_ptr[ADDR_WIDTH-1:0]);
        empty_c = (w_ptr == r_ptr);
    end

    // Round-robin grant: when both request, the producer not served last wins;
    // nothing is granted while full or while reset is held.
    always_comb begin
        grant0_c = 1'b0;
        grant1_c = 1'b0;
        if (rst && !full_c) begin
            if (bus.req0 && bus.req1) begin
                grant0_c = last;
                grant1_c = ~last;
            end else if (bus.req0) begin
                grant0_c = 1'b1;
            end else if (bus.req1) begin
                grant1_c = 1'b1;
            end
        end
    end

    // Write data follows the granted producer, defaulting to producer 0.
    always_comb begin
        mem_data_c = grant1_c ? bus.data1 : bus.data0;
        push       = grant0_c | grant1_c;
        pop_ok     = bus.pop & ~empty_c;
    end

    // Pointer, occupancy and round-robin state update on each accepted push/pop.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            w_ptr   <= '0;
            r_ptr   <= '0;
            count_q <= '0;
            last    <= 1'b1;
        end else begin
            if (push) begin
                w_ptr <= w_ptr + PW'(1);
                last  <= grant1_c;
            end
            if (pop_ok) begin
                r_ptr <= r_ptr + PW'(1);
            end
            case ({push, pop_ok})
                2'b10:   count_q <= count_q + PW'(1);
                2'b01:   count_q <= count_q - PW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    assign bus.grant0   = grant0_c;
    assign bus.grant1   = grant1_c;
    assign bus.mem_inc  = push;
    assign bus.mem_data = mem_data_c;
    assign bus.w_addr   = w_ptr[ADDR_WIDTH-1:0];
    assign bus.r_addr   = r_ptr[ADDR_WIDTH-1:0];
    assign bus.full     = full_c;
    assign bus.empty    = empty_c;
    assign bus.count    = count_q;

`ifdef FIFO_WR_ARB_ERR_EN
    logic ovf_err_q;
    logic unf_err_q;

    // Sticky error flags: a request while full or a pop while empty latches
    // until the next reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ovf_err_q <= 1'b0;
            unf_err_q <= 1'b0;
        end else begin
            if (full_c && (bus.req0 || bus.req1)) begin
                ovf_err_q <= 1'b1;
            end
            if (empty_c && bus.pop) begin
                unf_err_q <= 1'b1;
            end
        end
    end

    assign bus.ovf_err = ovf_err_q;
    assign bus.unf_err = unf_err_q;
`endif
endmodule
